// File: rtl/user_wb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant held for a full bus cycle.
// Optional slave watchdog enabled by defining USER_WB_ARB_TIMEOUT_EN.
module user_wb_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // master 0 (Caravel management)
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [DW/8-1:0]   wbs_sel_i,
  input  logic [AW-1:0]     wbs_adr_i,
  input  logic [DW-1:0]     wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DW-1:0]     wbs_dat_o,
  // master 1 (LA probes / user DMA)
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  output logic              m1_ack_o,
  output logic [DW-1:0]     m1_dat_o,
  // shared slave
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic              s_ack_i,
  input  logic [DW-1:0]     s_dat_i,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t state;
  state_t state_next;
  logic   last;
  logic   last_next;
  logic   req0;
  logic   req1;
  logic   granted;
  logic   owner_cyc;
  logic   expire;

  assign req0 = wbs_cyc_i & wbs_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  assign granted   = (state == GRANT0) || (state == GRANT1);
  assign owner_cyc = (state == GRANT0) ? wbs_cyc_i :
                     (state == GRANT1) ? m1_cyc_i  : 1'b0;

`ifdef USER_WB_ARB_TIMEOUT_EN
  localparam logic [DW-1:0] TIMEOUT_DATA = DW'(32'hDEAD_BEEF);

  logic [15:0] wd_count;
  logic        timeout_q;

  // An aborting master gets no forced ack; the grant simply ends.
  assign expire = granted && owner_cyc && !s_ack_i && (wd_count == TIMEOUT_LAST);

  // Counter only advances while granted; IDLE always separates grants so clearing there suffices.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd_count  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (!granted) begin
        wd_count <= 16'd0;
      end else if (!s_ack_i) begin
        wd_count <= wd_count + 16'd1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_LAST;
  assign expire             = 1'b0;
  assign timeout_o          = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    last_next  = last;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_sel_o    = '0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    wbs_ack_o  = 1'b0;
    wbs_dat_o  = '0;
    m1_ack_o   = 1'b0;
    m1_dat_o   = '0;

    case (state)
      IDLE: begin
        // On a tie the master opposite the previous owner wins.
        if (req0 && (!req1 || last)) begin
          state_next = GRANT0;
          last_next  = 1'b0;
        end else if (req1) begin
          state_next = GRANT1;
          last_next  = 1'b1;
        end
      end

      GRANT0: begin
        s_cyc_o   = wbs_cyc_i & !expire;
        s_stb_o   = wbs_stb_i & !expire;
        s_we_o    = wbs_we_i;
        s_sel_o   = wbs_sel_i;
        s_adr_o   = wbs_adr_i;
        s_dat_o   = wbs_dat_i;
        wbs_ack_o = (s_ack_i & wbs_cyc_i) | expire;
`ifdef USER_WB_ARB_TIMEOUT_EN
        wbs_dat_o = expire ? TIMEOUT_DATA : s_dat_i;
`else
        wbs_dat_o = s_dat_i;
`endif
        if (s_ack_i || !wbs_cyc_i || expire) begin
          state_next = IDLE;
        end
      end

      GRANT1: begin
        s_cyc_o  = m1_cyc_i & !expire;
        s_stb_o  = m1_stb_i & !expire;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = (s_ack_i & m1_cyc_i) | expire;
`ifdef USER_WB_ARB_TIMEOUT_EN
        m1_dat_o = expire ? TIMEOUT_DATA : s_dat_i;
`else
        m1_dat_o = s_dat_i;
`endif
        if (s_ack_i || !m1_cyc_i || expire) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_user_wb_arbiter.sv
// Directed self-checking bench for user_wb_arbiter (TIMEOUT=4 so the watchdog steps are short).
// Watchdog-specific steps are compiled in when USER_WB_ARB_TIMEOUT_EN is defined.
module tb_user_wb_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic        m1_ack_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic        timeout_o;

  int compared = 0;
  int mismatched = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  user_wb_arbiter #(.TIMEOUT(4), .AW(32), .DW(32)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .m1_cyc_i (m1_cyc_i),
    .m1_stb_i (m1_stb_i),
    .m1_we_i  (m1_we_i),
    .m1_sel_i (m1_sel_i),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_ack_o (m1_ack_o),
    .m1_dat_o (m1_dat_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_ack_i  (s_ack_i),
    .s_dat_i  (s_dat_i),
    .timeout_o(timeout_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Drive one master's request fields; m selects master 0 or 1.
  task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                               input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      wbs_cyc_i = cyc; wbs_stb_i = stb; wbs_we_i = we;
      wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
      m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
    end
  endtask

  // Advance to just after the next rising edge so new inputs never race the clock.
  task automatic tick();
    @(posedge wb_clk_i);
    #2;
  endtask

  task automatic checkAllZero(input string tag);
    checkFlag({tag, ".s_cyc"}, s_cyc_o, 1'b0);
    checkFlag({tag, ".s_stb"}, s_stb_o, 1'b0);
    checkFlag({tag, ".s_we"}, s_we_o, 1'b0);
    checkOutput({tag, ".s_sel"}, {28'd0, s_sel_o}, 32'd0);
    checkOutput({tag, ".s_adr"}, s_adr_o, 32'd0);
    checkOutput({tag, ".s_dat"}, s_dat_o, 32'd0);
    checkFlag({tag, ".wbs_ack"}, wbs_ack_o, 1'b0);
    checkOutput({tag, ".wbs_dat"}, wbs_dat_o, 32'd0);
    checkFlag({tag, ".m1_ack"}, m1_ack_o, 1'b0);
    checkOutput({tag, ".m1_dat"}, m1_dat_o, 32'd0);
    checkFlag({tag, ".timeout"}, timeout_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "[TB] time limit expired");
  end

  initial begin
    wb_rst_i = 1'b1;
    s_ack_i  = 1'b0;
    s_dat_i  = 32'd0;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    tick();
    #1;
    checkAllZero("reset");

    // Single master 0 write, zero-wait slave.
    wb_rst_i = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF);
    #1;
    checkFlag("wr.stb_before_grant", s_stb_o, 1'b0);
    tick();
    s_ack_i = 1'b1;
    #1;
    checkFlag("wr.s_stb", s_stb_o, 1'b1);
    checkFlag("wr.s_we", s_we_o, 1'b1);
    checkOutput("wr.s_adr", s_adr_o, 32'h3000_0004);
    checkOutput("wr.s_dat", s_dat_o, 32'h1234_5678);
    checkOutput("wr.s_sel", {28'd0, s_sel_o}, 32'hF);
    checkFlag("wr.wbs_ack", wbs_ack_o, 1'b1);
    checkFlag("wr.m1_ack", m1_ack_o, 1'b0);
    tick();
    s_ack_i = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checkFlag("wr.stb_after", s_stb_o, 1'b0);
    checkFlag("wr.ack_after", wbs_ack_o, 1'b0);

    // Reset, then both masters read continuously: order 0,1,0,1 with an idle gap each time.
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h3000_0100, 32'd0, 4'hF);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h3000_0200, 32'd0, 4'hF);
    #1;
    checkFlag("rr.idle0", s_cyc_o, 1'b0);
    for (int g = 0; g < 4; g++) begin
      tick();
      s_ack_i = 1'b1;
      s_dat_i = (g % 2 == 0) ? 32'hA5A5_0000 : 32'h5A5A_0001;
      #1;
      if (g % 2 == 0) begin
        checkOutput("rr.m0.s_adr", s_adr_o, 32'h3000_0100);
        checkFlag("rr.m0.ack", wbs_ack_o, 1'b1);
        checkOutput("rr.m0.dat", wbs_dat_o, 32'hA5A5_0000);
        checkFlag("rr.m0.other_ack", m1_ack_o, 1'b0);
        checkOutput("rr.m0.other_dat", m1_dat_o, 32'd0);
      end else begin
        checkOutput("rr.m1.s_adr", s_adr_o, 32'h3000_0200);
        checkFlag("rr.m1.ack", m1_ack_o, 1'b1);
        checkOutput("rr.m1.dat", m1_dat_o, 32'h5A5A_0001);
        checkFlag("rr.m1.other_ack", wbs_ack_o, 1'b0);
        checkOutput("rr.m1.other_dat", wbs_dat_o, 32'd0);
      end
      tick();
      s_ack_i = 1'b0;
      s_dat_i = 32'd0;
      #1;
      checkFlag("rr.gap.s_cyc", s_cyc_o, 1'b0);
      checkFlag("rr.gap.wbs_ack", wbs_ack_o, 1'b0);
      checkFlag("rr.gap.m1_ack", m1_ack_o, 1'b0);
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    tick();

    // Master 1 aborts in its third grant cycle; the slave acks one cycle later.
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h3000_0300, 32'd0, 4'hF);
    tick();
    #1;
    checkFlag("abort.g1.s_cyc", s_cyc_o, 1'b1);
    tick();
    #1;
    checkFlag("abort.g2.s_cyc", s_cyc_o, 1'b1);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h3000_0300, 32'd0, 4'hF);
    #1;
    checkFlag("abort.s_cyc", s_cyc_o, 1'b0);
    checkFlag("abort.m1_ack", m1_ack_o, 1'b0);
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h0BAD_0BAD;
    #1;
    checkFlag("abort.late.m1_ack", m1_ack_o, 1'b0);
    checkOutput("abort.late.m1_dat", m1_dat_o, 32'd0);
    tick();
    s_ack_i = 1'b0;
    s_dat_i = 32'd0;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h3000_0400, 32'd0, 4'hF);
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h0000_0777;
    #1;
    checkFlag("abort.next.s_cyc", s_cyc_o, 1'b1);
    checkOutput("abort.next.s_adr", s_adr_o, 32'h3000_0400);
    checkFlag("abort.next.wbs_ack", wbs_ack_o, 1'b1);
    checkOutput("abort.next.wbs_dat", wbs_dat_o, 32'h0000_0777);
    tick();
    s_ack_i = 1'b0;
    s_dat_i = 32'd0;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    tick();

    // Slave never acks master 0.
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h3000_0500, 32'd0, 4'hF);
    for (int c = 1; c <= 3; c++) begin
      tick();
      #1;
      checkFlag("wd.wait.s_cyc", s_cyc_o, 1'b1);
      checkFlag("wd.wait.wbs_ack", wbs_ack_o, 1'b0);
    end
    tick();
    #1;
`ifdef USER_WB_ARB_TIMEOUT_EN
    checkFlag("wd.exp.wbs_ack", wbs_ack_o, 1'b1);
    checkOutput("wd.exp.wbs_dat", wbs_dat_o, 32'hDEAD_BEEF);
    checkFlag("wd.exp.s_cyc", s_cyc_o, 1'b0);
    checkFlag("wd.exp.s_stb", s_stb_o, 1'b0);
    checkFlag("wd.exp.timeout_same", timeout_o, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checkFlag("wd.pulse", timeout_o, 1'b1);
    checkFlag("wd.after.wbs_ack", wbs_ack_o, 1'b0);
    tick();
    #1;
    checkFlag("wd.pulse_end", timeout_o, 1'b0);
`else
    checkFlag("nowd.c4.wbs_ack", wbs_ack_o, 1'b0);
    checkFlag("nowd.c4.s_cyc", s_cyc_o, 1'b1);
    tick();
    #1;
    checkFlag("nowd.c5.s_cyc", s_cyc_o, 1'b1);
    checkFlag("nowd.timeout", timeout_o, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    tick();
`endif

    // Slave acks exactly on the would-be expiry cycle: the slave data wins.
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h3000_0600, 32'd0, 4'hF);
    for (int c = 1; c <= 3; c++) tick();
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h0000_0042;
    #1;
    checkFlag("race.wbs_ack", wbs_ack_o, 1'b1);
    checkOutput("race.wbs_dat", wbs_dat_o, 32'h0000_0042);
    checkFlag("race.s_cyc", s_cyc_o, 1'b1);
    tick();
    s_ack_i = 1'b0;
    s_dat_i = 32'd0;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checkFlag("race.timeout", timeout_o, 1'b0);
    tick();

    // Reset while master 1 waits on the slave; a late ack must be dropped.
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h3000_0700, 32'hCAFE_F00D, 4'h3);
    tick();
    #1;
    checkFlag("rst.grant1.s_cyc", s_cyc_o, 1'b1);
    checkOutput("rst.grant1.s_adr", s_adr_o, 32'h3000_0700);
    wb_rst_i = 1'b1;
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h1111_2222;
    #1;
    checkAllZero("rst.mid");
    wb_rst_i = 1'b0;
    s_ack_i  = 1'b0;
    s_dat_i  = 32'd0;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h3000_0800, 32'd0, 4'hF);
    tick();
    #1;
    checkFlag("rst.tie.s_cyc", s_cyc_o, 1'b1);
    checkOutput("rst.tie.s_adr", s_adr_o, 32'h3000_0800);
    checkFlag("rst.tie.s_we", s_we_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/user_wb_arbiter.md
# user_wb_arbiter

Two-master, one-slave Wishbone classic arbiter placed in `user_project_wrapper` in front of the user project's Wishbone slave port. It shares the port between the Caravel management Wishbone master (`wbs_*`) and a second master (`m1_*`), which is driven from logic-analyzer probes or a user-side DMA. Arbitration is round-robin with the grant held for a whole bus cycle. An optional watchdog terminates transactions the slave never acknowledges.

## Interface
- `TIMEOUT`, default 255: cycles in GRANT without `s_ack_i` before the watchdog terminates; range 1..65535.
- `AW`, default 32: address width for both masters and the slave.
- `DW`, default 32: data width; select width is DW/8.

Ports:
- `wb_clk_i` input 1: clock for everything.
- `wb_rst_i` input 1: synchronous, active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` input 1 each: master 0 (Caravel) cycle, strobe and write enable.
- `wbs_sel_i` input DW/8, `wbs_adr_i` input AW, `wbs_dat_i` input DW: master 0 request fields.
- `wbs_ack_o` output 1, `wbs_dat_o` output DW: master 0 response.
- `m1_cyc_i`, `m1_stb_i`, `m1_we_i` input 1 each; `m1_sel_i` input DW/8; `m1_adr_i` input AW; `m1_dat_i` input DW: master 1 request.
- `m1_ack_o` output 1, `m1_dat_o` output DW: master 1 response.
- `s_cyc_o`, `s_stb_o`, `s_we_o` output 1 each; `s_sel_o` output DW/8; `s_adr_o` output AW; `s_dat_o` output DW: slave request.
- `s_ack_i` input 1, `s_dat_i` input DW: slave response.
- `timeout_o` output 1: one-cycle pulse when the watchdog fires.

## Operation
- Request: master n is requesting when its `cyc` and `stb` are both high.
- State machine has three states: IDLE, GRANT0, GRANT1.
- IDLE:
  - One requester: go to its GRANT state.
  - Both requesting: grant the master opposite `last`, a 1-bit register that resets to 1 so master 0 wins the first tie.
  - None: stay in IDLE.
  - On entering GRANTn, `last` <= n.
- GRANTn:
  - All `s_*` request outputs are combinational copies of master n's inputs.
  - `s_ack_i` and `s_dat_i` route combinationally to master n's `ack`/`dat`.
  - The other master sees `ack` = 0 and `dat` = 0.
- Leaving GRANTn:
  - `s_ack_i` high: ack delivered this cycle; next state is IDLE.
  - Master n drops `cyc` (abort): `s_cyc_o`/`s_stb_o` go low that same cycle, since they are combinational copies; next state is IDLE. An `s_ack_i` arriving in the abort cycle or later is not forwarded.
- In IDLE all `s_*` outputs and both master `ack`/`dat` outputs are 0.
- Multi-beat bursts are not supported: one ack ends the grant.
- Watchdog (only with the macro, see Configuration):
  - Counter cleared on entering GRANT; increments each GRANT cycle without `s_ack_i`.
  - When count == TIMEOUT-1 and `s_ack_i` is low, the arbiter instead:
    - forces master n `ack` = 1 and `dat` = 32'hDEAD_BEEF, zero-extended or truncated to DW;
    - drives `s_cyc_o` = `s_stb_o` = 0;
    - pulses `timeout_o`;
    - goes to IDLE.
  - `s_ack_i` and expiry in the same cycle: the slave ack wins; no timeout.

## Timing
- Reset (synchronous): state IDLE, `last` = 1, counter 0, `timeout_o` = 0. Every output is 0 in IDLE, so all outputs read 0 one cycle after reset is sampled.
- Request at edge k: GRANT registered at k+1; `s_cyc_o`/`s_stb_o` high during cycle k+1.
- A zero-wait slave acks in cycle k+1, so the master sees ack one cycle after its request was sampled.
- At least one IDLE cycle always separates consecutive grants.
- Reset asserted mid-grant: IDLE on the next edge. A pending ack is dropped and the master is not acked; the master must restart.
- `timeout_o` is registered: high in the cycle after expiry, for exactly one cycle.

## Configuration
- `USER_WB_ARB_TIMEOUT_EN` defined:
  - Watchdog counter is 16 bits.
  - Behaviour as described in Operation.
- Undefined:
  - No counter.
  - GRANT waits indefinitely for `s_ack_i` or for the master's abort.
  - `timeout_o` is tied to 0.

## Test plan
- Single master 0 write (adr 0x3000_0004, dat 0x1234_5678, sel 0xF), slave acks in its first granted cycle. Required: `s_stb_o` high exactly one cycle after the request is sampled; `wbs_ack_o` high the same cycle; `m1_ack_o` stays 0.
- Both masters request reads in the same cycle straight after reset, and both keep requesting. Required: grant order 0,1,0,1; `wbs_dat_o`/`m1_dat_o` return the slave values 0xA5A5_0000 / 0x5A5A_0001; one IDLE cycle between grants.
- Master 1 aborts (`m1_cyc_i` drops) two cycles into a grant, slave acks one cycle later. Required: `s_cyc_o` low in the abort cycle; `m1_ack_o` never high; the next master 0 request is granted normally.
- With the macro, TIMEOUT=4, slave never acks. Required: `wbs_ack_o` = 1 with `wbs_dat_o` = 0xDEAD_BEEF in the 4th grant cycle; `timeout_o` pulses one cycle later.
- With the macro, TIMEOUT=4, slave acks on the expiry cycle with data 0x0000_0042. Required: `wbs_dat_o` = 0x0000_0042; `timeout_o` stays 0.
- `wb_rst_i` asserted while GRANT1 is waiting on the slave. Required: all outputs 0 on the next cycle; after reset release, a simultaneous request from both masters grants master 0 first.
